// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit and its data memory.
package load_store_unit_pkg;

    localparam int LSU_ADDR_WIDTH = 10;
    localparam int LSU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
interface load_store_unit_if
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_fault;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    // Execute stage + memory side.
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_fault,
        output rsp_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_fault,
        input  rsp_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane merge for sub-word stores, lane extract/extend for loads, alignment check.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_store_data,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    logic [31:0] w_shifted;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       w_sel;
            logic [7:0] w_src;

            always_comb begin
                w_sel = 1'b0;
                w_src = 8'h00;
                case (i_size)
                    SIZE_BYTE: begin
                        w_sel = (i_addr_lo == LANE);
                        w_src = i_wdata[7:0];
                    end
                    SIZE_HALF: begin
                        w_sel = (i_addr_lo[1] == LANE[1]);
                        w_src = i_wdata[8*(gi%2) +: 8];
                    end
                    SIZE_WORD: begin
                        w_sel = 1'b1;
                        w_src = i_wdata[8*gi +: 8];
                    end
                    default: begin
                        w_sel = 1'b0;
                        w_src = 8'h00;
                    end
                endcase
            end

            assign o_store_data[8*gi +: 8] = w_sel ? w_src : i_rdata[8*gi +: 8];
        end
    endgenerate

    // Addressed lane moved down to bit 0 before extension.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_load_data = 32'h0;
        o_misalign  = 1'b0;
        case (i_size)
            SIZE_BYTE: o_load_data = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF: begin
                o_load_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
                o_misalign  = i_addr_lo[0];
            end
            SIZE_WORD: begin
                o_load_data = w_shifted;
                o_misalign  = |i_addr_lo;
            end
            default: o_load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: IDLE -> ACCESS -> RESP, one response per accepted request.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    state_e                r_state;
    state_e                w_state_next;
    req_t                  r_req;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_fault;

    logic                  w_req_ready;
    logic                  w_rsp_valid;
    logic                  w_mem_we;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_range_fault;
    logic                  w_size_fault;
    logic                  w_fault;
    logic [DATA_WIDTH-1:0] w_store_data;
    logic [DATA_WIDTH-1:0] w_load_data;

    lsu_lane_align u_lane_align (
        .i_size       (r_req.size),
        .i_signed     (r_req.sign),
        .i_addr_lo    (r_req.addr[1:0]),
        .i_rdata      (bus.mem_rdata),
        .i_wdata      (r_req.wdata),
        .o_store_data (w_store_data),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

    assign w_range_fault = |r_req.addr[31:ADDR_WIDTH+2];
    assign w_size_fault  = (r_req.size == SIZE_ILL);
    assign w_fault       = w_misalign | w_range_fault | w_size_fault;
    assign w_accept      = bus.req_valid & w_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    if (bus.rsp_ready) w_state_next = w_accept ? ACCESS : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Write enable comes straight from state so an async reset kills it at once.
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            IDLE:    w_req_ready = 1'b1;
            ACCESS:  w_mem_we    = r_req.write & ~w_fault;
            RESP: begin
                w_rsp_valid = 1'b1;
                w_req_ready = bus.rsp_ready;
            end
            default: w_req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req <= '{write: bus.req_write, size: bus.req_size, sign: bus.req_signed,
                           addr: bus.req_addr, wdata: bus.req_wdata};
            end
            if (r_state == ACCESS) begin
                r_rsp_fault <= w_fault;
                r_rsp_rdata <= (w_fault || r_req.write) ? '0 : w_load_data;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_req.addr[ADDR_WIDTH+1:2];
    assign bus.mem_wdata = w_mem_we ? w_store_data : '0;

endmodule
